cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Common Data Bus (CDB) producer side. Collects completed results from NUM_SRC
//  execution units (ALU, MUL, DIV, LD) and grants one per cycle, round-robin.
//  Drives one registered broadcast (valid, tag, data) that every reservation
//  station register snoops to wake up waiting operands.
// PARAMETERS
//  NUM_SRC  4   number of result sources; legal range 2..8
//  DATA_W   32  result data width
//  TAG_W    6   ROB/destination tag width
// PORTS
//  clk       in   1               clock, rising edge
//  rst       in   1               asynchronous reset, active-low (0 = reset)
//  flush     in   1               synchronous pipeline flush, active-high
//  src_valid in   NUM_SRC         src i has a result pending
//  src_tag   in   NUM_SRC*TAG_W   src i tag at [i*TAG_W +: TAG_W]
//  src_data  in   NUM_SRC*DATA_W  src i data at [i*DATA_W +: DATA_W]
//  src_ready out  NUM_SRC         grant; src i result accepted this cycle
//  cdb_valid out  1               broadcast valid
//  cdb_tag   out  TAG_W           broadcast tag
//  cdb_data  out  DATA_W          broadcast data
//  cdb_src   out  $clog2(NUM_SRC) index of the source being broadcast (debug/perf)
// BEHAVIOUR
//  Reset (rst=0, async): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0.
//   src_ready=0 while rst=0.
//  Handshake: a transfer occurs when src_valid[i] & src_ready[i].
//   - A source holds valid, tag and data stable until it is granted.
//   - Once valid is asserted, a source does not drop it before it is granted.
//   - src_ready is combinational from src_valid, rr_ptr and flush.
//   - src_ready is one-hot or zero.
//   - src_ready[i] never asserts without src_valid[i].
//  Arbitration: scan i = rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
//   - The first index with src_valid set is granted.
//   - No request in a cycle: no grant, rr_ptr unchanged.
//  Pointer: after a grant to index g, rr_ptr <= (g+1) mod NUM_SRC.
//   - Wraps from NUM_SRC-1 to 0.
//   - NUM_SRC need not be a power of 2; the modulo is explicit.
//  Latency: exactly 1 cycle.
//   - Grant in cycle N gives cdb_valid=1 in cycle N+1.
//   - In N+1, cdb_tag, cdb_data and cdb_src carry the granted source's values.
//  No grant in cycle N: cdb_valid=0 in N+1.
//   - cdb_tag and cdb_data hold their previous values; consumers qualify with
//     cdb_valid.
//  Throughput: one broadcast per cycle; no bubble between back-to-back grants.
//  Fairness: with all sources continuously valid, each source is granted exactly
//   once in every NUM_SRC consecutive cycles.
//  Flush (flush=1 in cycle N):
//   - src_ready=0 in cycle N; no grant.
//   - cdb_valid=0 in N+1, even if a grant occurred in N-1 (that broadcast still
//     appears in cycle N).
//   - rr_ptr is retained.
//   - Sources see no grant during the flush and drop their requests themselves.
//  Simultaneous flush and rst=0: reset wins.
//  Reset mid-operation:
//   - Outputs clear immediately (async).
//   - The first grant after reset release scans from index 0.
//  No internal buffering: one-cycle output register only; no backpressure from
//   the CDB side.
// TESTING
//  1 Reset: rst=0 with all src_valid=1.
//    -> src_ready=0, cdb_valid=0, cdb_tag=0, cdb_data=0.
//    Release rst -> src 0 granted first.
//  2 Single source: src_valid=4'b0100, tag=6'h2A, data=32'hDEADBEEF in cycle N.
//    -> src_ready=4'b0100 in N.
//    -> In N+1: cdb_valid=1, cdb_tag=2A, cdb_data=DEADBEEF, cdb_src=2.
//    -> rr_ptr=3.
//  3 All valid for 8 cycles, rr_ptr=0.
//    -> Grant order 0,1,2,3,0,1,2,3.
//    -> cdb_valid=1 in all 8 following cycles (no bubbles).
//  4 Wrap and skip: rr_ptr=3, src_valid=4'b0011.
//    -> Grant 0, then grant 1, then rr_ptr=2.
//    Then src_valid=0 -> cdb_valid=0 and rr_ptr stays 2.
//  5 Flush: grant src1 in N-1, flush=1 in N with src_valid=4'b1111.
//    -> In N: src1 broadcast on CDB, src_ready=0.
//    -> cdb_valid=0 in N+1; rr_ptr unchanged.
//  6 Async reset mid-stream: rst falls between clock edges while cdb_valid=1.
//    -> cdb_valid=0 immediately, not at the next edge.
//  Checkers, every cycle:
//   - src_ready is one-hot or zero.
//   - src_ready[i] implies src_valid[i].
//   - A scoreboard matches each accepted result to exactly one cdb_valid beat.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Bundle of source-side and broadcast-side signals for the CDB arbiter.
// Handshake: source i transfers its result in a cycle where
// src_valid[i] & src_ready[i] is high. A source keeps valid, tag and data
// stable until it is granted. src_ready is one-hot or zero, and it never
// asserts without the matching src_valid. The broadcast side has no ready
// signal: the arbiter presents one beat per cycle, qualified by cdb_valid.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6
) ();

  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  // Arbiter side: consumes source requests, drives grants and the broadcast.
  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  // Producer/observer side: execution units and CDB snoopers.
  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus producer: round-robin selection of one completed result per
// cycle from NUM_SRC execution units, broadcast through a one-cycle register.
// The round-robin pointer is exported on dbg_rr_ptr_o for checkers.
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  cdb_arbiter_if.slave               bus,
  output logic [$clog2(NUM_SRC)-1:0] dbg_rr_ptr_o
);

  localparam int PTR_W = $clog2(NUM_SRC);
  // One extra bit so rr_ptr + offset cannot overflow before the modulo.
  localparam int CW    = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

  // Round-robin pointer: index scanned first in the current cycle.
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Registered broadcast.
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q,  cdb_data_d;
  logic [PTR_W-1:0]   cdb_src_q,   cdb_src_d;

  // Arbitration results.
  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [CW-1:0]      cand;
  logic               grant_fire;
  logic [NUM_SRC-1:0] src_ready_d;
  logic [TAG_W-1:0]   gnt_tag;
  logic [DATA_W-1:0]  gnt_data;

  // Scan from rr_ptr upward with explicit wrap; first requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_SRC)) begin
        cand = cand - CW'(NUM_SRC);
      end
      if (!gnt_found && bus.src_valid[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // A grant is issued only outside flush and reset; rst is folded in so the
  // ready outputs are low for the whole reset interval, not just after an edge.
  assign grant_fire = gnt_found & ~flush & rst;

  // One-hot grant vector back to the sources.
  always_comb begin
    src_ready_d = '0;
    if (grant_fire) begin
      src_ready_d[gnt_idx] = 1'b1;
    end
  end

  assign bus.src_ready = src_ready_d;

  // Select the granted source's tag and data with constant slices.
  always_comb begin
    gnt_tag  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        gnt_tag  = bus.src_tag[i*TAG_W +: TAG_W];
        gnt_data = bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: load the broadcast on a grant and advance the pointer past
  // the winner; otherwise drop valid and keep tag/data/src and pointer.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = grant_fire;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant_fire) begin
      cdb_tag_d  = gnt_tag;
      cdb_data_d = gnt_data;
      cdb_src_d  = gnt_idx;
      rr_ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // State registers; reset clears the broadcast and restarts the scan at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
  assign dbg_rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-cycle monitor and scoreboard.
module tb_cdb_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int SW = 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [SW-1:0] dbg_rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW+TW+DW-1:0] exp_q[$];
  logic [SW+TW+DW-1:0] m_ent;
  logic [SW-1:0]       m_idx;

  cdb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_defaults();
    for (int i = 0; i < NS; i++) begin
      bus.src_tag[i*TW +: TW]  = TW'(16 + i);
      bus.src_data[i*DW +: DW] = 32'hA000_0000 + DW'(i);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic [SW-1:0] src);
    chk({tag, "_valid"}, 64'(bus.cdb_valid), 64'h1);
    chk({tag, "_src"},   64'(bus.cdb_src),   64'(src));
    chk({tag, "_tag"},   64'(bus.cdb_tag),   64'(TW'(16) + TW'(src)));
    chk({tag, "_data"},  64'(bus.cdb_data),  64'(32'hA000_0000 + 32'(src)));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    chk("rdy_onehot0", 64'($onehot0(bus.src_ready)), 64'h1);
    chk("rdy_implies_vld", 64'(bus.src_ready & ~bus.src_valid), 64'h0);
    if (bus.cdb_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'h1, 64'h0);
      end else begin
        m_ent = exp_q.pop_front();
        chk("sb_beat", 64'({bus.cdb_src, bus.cdb_tag, bus.cdb_data}), 64'(m_ent));
      end
    end
    if (|(bus.src_ready & bus.src_valid)) begin
      m_idx = '0;
      for (int i = 0; i < NS; i++) begin
        if (bus.src_ready[i]) m_idx = SW'(i);
      end
      exp_q.push_back({m_idx, bus.src_tag[m_idx*TW +: TW], bus.src_data[m_idx*DW +: DW]});
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b0;
    flush         = 1'b0;
    load_defaults();
    bus.src_valid = 4'hF;

    // Reset with all sources requesting.
    @(negedge clk);
    chk("rst_ready", 64'(bus.src_ready), 64'h0);
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    chk("rst_cdb_tag", 64'(bus.cdb_tag), 64'h0);
    chk("rst_cdb_data", 64'(bus.cdb_data), 64'h0);
    chk("rst_cdb_src", 64'(bus.cdb_src), 64'h0);
    chk("rst_ptr", 64'(dbg_rr_ptr), 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(bus.src_ready), 64'h1);
    cyc();
    bus.src_valid = 4'h0;
    chk_cdb("rel_cdb", 2'd0);
    chk("rel_ptr", 64'(dbg_rr_ptr), 64'h1);
    @(negedge clk);
    chk("idle_ready", 64'(bus.src_ready), 64'h0);
    cyc();
    chk("idle_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    chk("hold_tag", 64'(bus.cdb_tag), 64'h10);
    chk("hold_data", 64'(bus.cdb_data), 64'hA000_0000);
    chk("idle_ptr", 64'(dbg_rr_ptr), 64'h1);

    // Single source 2 with its own tag/data.
    bus.src_tag[2*TW +: TW]  = 6'h2A;
    bus.src_data[2*DW +: DW] = 32'hDEAD_BEEF;
    bus.src_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 64'(bus.src_ready), 64'h4);
    cyc();
    bus.src_valid = 4'h0;
    chk("single_valid", 64'(bus.cdb_valid), 64'h1);
    chk("single_tag", 64'(bus.cdb_tag), 64'h2A);
    chk("single_data", 64'(bus.cdb_data), 64'hDEAD_BEEF);
    chk("single_src", 64'(bus.cdb_src), 64'h2);
    chk("single_ptr", 64'(dbg_rr_ptr), 64'h3);
    load_defaults();

    // Wrap and skip from pointer 3 with sources 0 and 1.
    bus.src_valid = 4'b0011;
    @(negedge clk);
    chk("wrap_ready0", 64'(bus.src_ready), 64'h1);
    cyc();
    bus.src_valid = 4'b0010;
    chk_cdb("wrap_cdb0", 2'd0);
    chk("wrap_ptr0", 64'(dbg_rr_ptr), 64'h1);
    @(negedge clk);
    chk("wrap_ready1", 64'(bus.src_ready), 64'h2);
    cyc();
    bus.src_valid = 4'h0;
    chk_cdb("wrap_cdb1", 2'd1);
    chk("wrap_ptr1", 64'(dbg_rr_ptr), 64'h2);
    @(negedge clk);
    chk("wrap_ready_idle", 64'(bus.src_ready), 64'h0);
    cyc();
    chk("wrap_idle_valid", 64'(bus.cdb_valid), 64'h0);
    chk("wrap_idle_ptr", 64'(dbg_rr_ptr), 64'h2);

    // Bring pointer to 0 via source 3, then all valid for 8 cycles.
    bus.src_valid = 4'b1000;
    @(negedge clk);
    chk("pre_ready3", 64'(bus.src_ready), 64'h8);
    cyc();
    bus.src_valid = 4'hF;
    chk_cdb("pre_cdb3", 2'd3);
    chk("pre_ptr", 64'(dbg_rr_ptr), 64'h0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("rr_ready", 64'(bus.src_ready), 64'(4'b0001 << (j % 4)));
      cyc();
      if (j == 7) bus.src_valid = 4'h0;
      chk_cdb("rr_cdb", SW'(j % 4));
    end
    chk("rr_ptr_end", 64'(dbg_rr_ptr), 64'h0);

    // Flush in the cycle after a grant to source 1.
    bus.src_valid = 4'b0010;
    @(negedge clk);
    chk("fl_pre_ready", 64'(bus.src_ready), 64'h2);
    cyc();
    bus.src_valid = 4'hF;
    flush = 1'b1;
    chk_cdb("fl_cdb", 2'd1);
    @(negedge clk);
    chk("fl_ready", 64'(bus.src_ready), 64'h0);
    cyc();
    flush = 1'b0;
    bus.src_valid = 4'h0;
    chk("fl_after_valid", 64'(bus.cdb_valid), 64'h0);
    chk("fl_ptr", 64'(dbg_rr_ptr), 64'h2);

    // Asynchronous reset while a broadcast is on the bus.
    bus.src_valid = 4'b0100;
    @(negedge clk);
    chk("ar_ready", 64'(bus.src_ready), 64'h4);
    cyc();
    bus.src_valid = 4'hF;
    chk("ar_pre_valid", 64'(bus.cdb_valid), 64'h1);
    #2;
    rst   = 1'b0;
    flush = 1'b1;
    exp_q.delete();
    #1;
    chk("ar_valid", 64'(bus.cdb_valid), 64'h0);
    chk("ar_tag", 64'(bus.cdb_tag), 64'h0);
    chk("ar_data", 64'(bus.cdb_data), 64'h0);
    chk("ar_src", 64'(bus.cdb_src), 64'h0);
    chk("ar_ptr", 64'(dbg_rr_ptr), 64'h0);
    @(negedge clk);
    chk("ar_ready_in_rst", 64'(bus.src_ready), 64'h0);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    chk("ar_first_ready", 64'(bus.src_ready), 64'h1);
    cyc();
    bus.src_valid = 4'h0;
    chk_cdb("ar_first_cdb", 2'd0);
    chk("ar_first_ptr", 64'(dbg_rr_ptr), 64'h1);

    cyc();
    cyc();
    chk("sb_drain", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
